// File: rtl/axis_frame_driver.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_driver
// Description : Host end of the accelerator stream link. On start it streams
//               TX_DATA_NUM words read from a combinational TX memory out on
//               the master port. It then accepts up to RX_DATA_NUM result
//               words on the slave port and writes them to an RX memory. RX
//               frame length / TLAST disagreement is flagged in len_err.
// Ports       : clk, rst_n            clock, async active-low reset
//               start, busy, done     transaction control / status
//               len_err               sticky RX length/TLAST mismatch flag
//               tx_adr, tx_data       TX memory read port (comb read)
//               m_data/valid/last/ready  master stream to accelerator
//               s_data/valid/last/ready  slave stream from accelerator
//               rx_adr/data/wr        RX memory write port
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_driver #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  TX_DATA_NUM = 8,
    parameter int  RX_DATA_NUM = 4,
    localparam int TX_ADR_W    = $clog2(TX_DATA_NUM),
    localparam int RX_ADR_W    = $clog2(RX_DATA_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err,
    output logic [TX_ADR_W-1:0]   tx_adr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [RX_ADR_W-1:0]   rx_adr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_wr
);

    localparam logic [TX_ADR_W-1:0] c_TX_LAST = TX_ADR_W'(TX_DATA_NUM - 1);
    localparam logic [RX_ADR_W-1:0] c_RX_LAST = RX_ADR_W'(RX_DATA_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [TX_ADR_W-1:0] r_txCnt;
    logic [TX_ADR_W-1:0] w_txCntNext;
    logic [RX_ADR_W-1:0] r_rxCnt;
    logic [RX_ADR_W-1:0] w_rxCntNext;
    logic                r_lenErr;
    logic                w_lenErrNext;
    logic                w_rxAtEnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_txCnt  <= '0;
            r_rxCnt  <= '0;
            r_lenErr <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_txCnt  <= w_txCntNext;
            r_rxCnt  <= w_rxCntNext;
            r_lenErr <= w_lenErrNext;
        end
    end

    // All outputs decode from the registered state, so an asynchronous reset
    // forces them low immediately and no beat can complete under reset.
    assign w_rxAtEnd = (r_rxCnt == c_RX_LAST);

    always_comb begin
        w_nextState  = r_state;
        w_txCntNext  = r_txCnt;
        w_rxCntNext  = r_rxCnt;
        w_lenErrNext = r_lenErr;
        done         = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_data       = '0;
        s_ready      = 1'b0;
        rx_wr        = 1'b0;
        tx_adr       = r_txCnt;
        rx_adr       = r_rxCnt;
        rx_data      = s_data;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState  = S_SEND;
                    w_txCntNext  = '0;
                    w_rxCntNext  = '0;
                    w_lenErrNext = 1'b0;
                end
            end

            S_SEND: begin
                // Valid is held for the whole state; tx_adr only moves on a
                // completed beat, so m_data/m_last stay put under backpressure.
                m_valid = 1'b1;
                m_data  = tx_data;
                m_last  = (r_txCnt == c_TX_LAST);
                if (m_ready) begin
                    if (r_txCnt == c_TX_LAST) begin
                        w_txCntNext = '0;
                        w_nextState = S_RECV;
                    end else begin
                        w_txCntNext = r_txCnt + 1'b1;
                    end
                end
            end

            S_RECV: begin
                s_ready = 1'b1;
                rx_wr   = s_valid;
                if (s_valid) begin
                    // Frame ends on whichever comes first: TLAST or the
                    // expected word count. They must coincide for a clean frame.
                    if (s_last || w_rxAtEnd) begin
                        w_rxCntNext = '0;
                        w_nextState = S_DONE;
                        if (s_last != w_rxAtEnd) begin
                            w_lenErrNext = 1'b1;
                        end
                    end else begin
                        w_rxCntNext = r_rxCnt + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign len_err = r_lenErr;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_driver
// Description : Directed self-checking bench for axis_frame_driver. A TX
//               memory model feeds tx_data; monitors record transmitted
//               beats, RX memory writes and stream-protocol violations.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        len_err;
    logic [2:0]  tx_adr;
    logic [31:0] tx_data;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [1:0]  rx_adr;
    logic [31:0] rx_data;
    logic        rx_wr;

    axis_frame_driver #(
        .DATA_WIDTH (32),
        .TX_DATA_NUM(8),
        .RX_DATA_NUM(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .len_err(len_err),
        .tx_adr (tx_adr),
        .tx_data(tx_data),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_last (m_last),
        .m_ready(m_ready),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_last (s_last),
        .s_ready(s_ready),
        .rx_adr (rx_adr),
        .rx_data(rx_data),
        .rx_wr  (rx_wr)
    );

    always #5 clk = ~clk;

    logic [31:0] txMem [8];
    assign tx_data = txMem[tx_adr];

    // Monitors
    logic [31:0] sentQ[$];
    logic        lastQ[$];
    logic [31:0] rxMem [4];
    int          rxWrs      = 0;
    int          overlapErr = 0;
    int          bubbleErr  = 0;
    int          stallErr   = 0;
    logic        pValid     = 1'b0;
    logic        pReady     = 1'b0;
    logic [31:0] pData      = '0;

    always @(posedge clk) begin
        if (m_valid && m_ready) begin
            sentQ.push_back(m_data);
            lastQ.push_back(m_last);
        end
        if (rx_wr) begin
            rxMem[rx_adr] <= rx_data;
            rxWrs         <= rxWrs + 1;
        end
        if (m_valid && s_ready)                   overlapErr <= overlapErr + 1;
        if (busy && !m_valid && !s_ready && !done) bubbleErr <= bubbleErr + 1;
        if (pValid && !pReady && (!m_valid || m_data !== pData)) stallErr <= stallErr + 1;
        pValid <= m_valid;
        pReady <= m_ready;
        pData  <= m_data;
    end

    int   nCmp = 0;
    int   nErr = 0;
    logic lenErrAtStart;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction. readyMode 0: m_ready held high; 1: 1,0,0,1 pattern.
    // Result source returns nRx words rxBase+i, s_last on index lastAt (-1 = never).
    // noise: pulse start during SEND/RECV and s_valid during SEND.
    task automatic doFrame(input int readyMode, input int nRx, input int lastAt,
                           input logic [31:0] rxBase, input bit noise, output int cyc);
        int rxIdx;
        bit seen;
        rxIdx   = 0;
        seen    = 0;
        start   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        start = 1'b0;
        lenErrAtStart = len_err;
        cyc = 2;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            m_ready = (readyMode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            start   = noise && busy;
            if (s_ready && rxIdx < nRx) begin
                s_valid = 1'b1;
                s_data  = rxBase + 32'(rxIdx);
                s_last  = (rxIdx == lastAt);
                rxIdx++;
            end else if (noise && m_valid && (k % 2 == 0)) begin
                s_valid = 1'b1;
                s_data  = 32'hEE;
                s_last  = 1'b1;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            tick();
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int cyc;
        int sBase;
        int wBase;
        int oBase;
        int bBase;
        int tBase;

        for (int i = 0; i < 8; i++) txMem[i] = 32'h10 + 32'(i);
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_mvalid",  32'(m_valid), 32'd0);
        chk("rst_mlast",   32'(m_last),  32'd0);
        chk("rst_sready",  32'(s_ready), 32'd0);
        chk("rst_lenerr",  32'(len_err), 32'd0);
        chk("rst_txadr",   32'(tx_adr),  32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal frame
        sBase = sentQ.size(); wBase = rxWrs; oBase = overlapErr; bBase = bubbleErr;
        doFrame(0, 4, 3, 32'hA0, 1'b0, cyc);
        chk("nom_latency", 32'(cyc), 32'd14);
        chk("nom_txcount", 32'(sentQ.size() - sBase), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("nom_tx%0d", i),   sentQ[sBase + i],      32'h10 + 32'(i));
            chk($sformatf("nom_last%0d", i), 32'(lastQ[sBase + i]), 32'(i == 7));
        end
        chk("nom_rxwrs", 32'(rxWrs - wBase), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("nom_rx%0d", i), rxMem[i], 32'hA0 + 32'(i));
        chk("nom_lenerr",  32'(len_err), 32'd0);
        chk("nom_overlap", 32'(overlapErr - oBase), 32'd0);
        chk("nom_bubble",  32'(bubbleErr - bBase), 32'd0);
        tick();
        chk("nom_idle", 32'(busy), 32'd0);

        // Backpressure
        sBase = sentQ.size(); wBase = rxWrs; oBase = overlapErr; bBase = bubbleErr; tBase = stallErr;
        doFrame(1, 4, 3, 32'hB0, 1'b0, cyc);
        chk("bp_txcount", 32'(sentQ.size() - sBase), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_tx%0d", i), sentQ[sBase + i], 32'h10 + 32'(i));
        chk("bp_stall",   32'(stallErr - tBase),   32'd0);
        chk("bp_bubble",  32'(bubbleErr - bBase),  32'd0);
        chk("bp_overlap", 32'(overlapErr - oBase), 32'd0);
        chk("bp_rxwrs",   32'(rxWrs - wBase),      32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_rx%0d", i), rxMem[i], 32'hB0 + 32'(i));
        chk("bp_lenerr", 32'(len_err), 32'd0);
        tick();

        // Early last on second result word
        wBase = rxWrs;
        doFrame(0, 4, 1, 32'hC0, 1'b0, cyc);
        chk("early_latency", 32'(cyc), 32'd12);
        chk("early_rxwrs",   32'(rxWrs - wBase), 32'd2);
        chk("early_rx0",     rxMem[0], 32'hC0);
        chk("early_rx1",     rxMem[1], 32'hC1);
        chk("early_rx2",     rxMem[2], 32'hB2);
        chk("early_lenerr",  32'(len_err), 32'd1);
        tick();
        chk("early_idle",    32'(busy), 32'd0);
        chk("early_sticky",  32'(len_err), 32'd1);

        // Missing last
        wBase = rxWrs;
        doFrame(0, 4, -1, 32'hD0, 1'b0, cyc);
        chk("miss_rxwrs",  32'(rxWrs - wBase), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("miss_rx%0d", i), rxMem[i], 32'hD0 + 32'(i));
        chk("miss_lenerr", 32'(len_err), 32'd1);
        tick();

        // Ignored start / s_valid noise; also next start clears len_err
        sBase = sentQ.size(); wBase = rxWrs;
        doFrame(0, 4, 3, 32'hE0, 1'b1, cyc);
        chk("noise_lenerr_cleared", 32'(lenErrAtStart), 32'd0);
        chk("noise_latency", 32'(cyc), 32'd14);
        chk("noise_txcount", 32'(sentQ.size() - sBase), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("noise_tx%0d", i), sentQ[sBase + i], 32'h10 + 32'(i));
        chk("noise_rxwrs", 32'(rxWrs - wBase), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("noise_rx%0d", i), rxMem[i], 32'hE0 + 32'(i));
        chk("noise_lenerr", 32'(len_err), 32'd0);
        tick();
        chk("noise_idle", 32'(busy), 32'd0);

        // Reset mid-frame after the third TX beat
        sBase   = sentQ.size();
        start   = 1'b1;
        m_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sentQ.size() - sBase >= 3) break;
            tick();
        end
        chk("mid_beats",   32'(sentQ.size() - sBase), 32'd3);
        chk("mid_txadr",   32'(tx_adr),  32'd3);
        chk("mid_mvalid",  32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(busy),    32'd0);
        chk("mid_rst_mvalid", 32'(m_valid), 32'd0);
        chk("mid_rst_mlast",  32'(m_last),  32'd0);
        chk("mid_rst_sready", 32'(s_ready), 32'd0);
        chk("mid_rst_done",   32'(done),    32'd0);
        chk("mid_rst_rxwr",   32'(rx_wr),   32'd0);
        chk("mid_rst_txadr",  32'(tx_adr),  32'd0);
        tick();
        tick();
        chk("mid_rst_nobeat", 32'(sentQ.size() - sBase), 32'd3);
        rst_n = 1'b1;
        tick();
        sBase = sentQ.size();
        doFrame(0, 4, 3, 32'hF0, 1'b0, cyc);
        chk("restart_latency", 32'(cyc), 32'd14);
        chk("restart_txcount", 32'(sentQ.size() - sBase), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("restart_tx%0d", i), sentQ[sBase + i], 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) chk($sformatf("restart_rx%0d", i), rxMem[i], 32'hF0 + 32'(i));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_frame_driver.md
Name: axis_frame_driver

Overview:
- AXI-Stream frame driver that loads the CNN accelerator's stream wrapper and collects its results.
- On start, streams TX_DATA_NUM words from a local TX memory port out on its master side (into the accelerator's slave input).
- Then accepts RX_DATA_NUM result words on its slave side and writes them to an RX memory port.
- Used in SoC-side glue and the system bench as the host end of the accelerator stream link.

Parameters:
- DATA_WIDTH, 32, width of every stream word and memory data port.
- TX_DATA_NUM, 8, words sent per frame (≥2).
- RX_DATA_NUM, 4, words expected back per frame (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request one frame transaction; sampled only in IDLE.
- busy  out  1  high from cycle after start accepted until DONE exits.
- done  out  1  one-cycle pulse at end of transaction.
- len_err  out  1  sticky; RX frame length/TLAST mismatch in last transaction.
- tx_adr  out  $clog2(TX_DATA_NUM)  TX memory read address (combinational-read memory).
- tx_data  in  DATA_WIDTH  TX memory read data for tx_adr, same cycle.
- m_data  out  DATA_WIDTH  stream data to accelerator.
- m_valid  out  1  stream valid.
- m_last  out  1  marks final TX word.
- m_ready  in  1  accelerator ready.
- s_data  in  DATA_WIDTH  result data from accelerator.
- s_valid  in  1  result valid.
- s_last  in  1  result last.
- s_ready  out  1  driver ready for result.
- rx_adr  out  $clog2(RX_DATA_NUM)  RX memory write address.
- rx_data  out  DATA_WIDTH  RX memory write data (= s_data).
- rx_wr  out  1  RX memory write strobe.

Behaviour:
- Reset (asynchronous, rst_n low, any time incl. mid-frame):
  - state IDLE, both counters 0, len_err 0.
  - busy, done, m_valid, m_last, s_ready, rx_wr all 0.
  - No partial beat is completed after reset.
- States: IDLE, SEND, RECV, DONE.
- IDLE: start=1 → SEND next cycle; clears len_err and both counters. start in any other state is ignored.
- SEND:
  - tx_adr = tx_cnt; m_data = tx_data (combinational); m_valid = 1; m_last = (tx_cnt == TX_DATA_NUM-1).
  - Beat transfers when m_valid & m_ready; tx_cnt increments only on a transfer.
  - m_ready low holds m_data, tx_adr and m_last stable. No valid drop, no bubble inserted by the driver.
  - Final-beat transfer: tx_cnt wraps to 0 → RECV.
- RECV:
  - s_ready = 1; rx_adr = rx_cnt; rx_data = s_data; rx_wr = s_valid (combinational).
  - On s_valid, rx_cnt increments.
  - Beat with s_last=1 and rx_cnt < RX_DATA_NUM-1 (early last): word written, len_err set, → DONE.
  - Beat with rx_cnt == RX_DATA_NUM-1 and s_last=0: word written, len_err set, → DONE.
  - Beat with rx_cnt == RX_DATA_NUM-1 and s_last=1: word written, → DONE, len_err unchanged (0).
  - rx_cnt wraps to 0 on exit.
- DONE: done=1 for exactly one cycle; busy still 1; s_ready=0, m_valid=0 → IDLE.
- busy = (state != IDLE).
- Latency:
  - First m_valid in the cycle after start is sampled.
  - With m_ready and s_valid held high: start → done = 1 + TX_DATA_NUM + RX_DATA_NUM + 1 cycles (14 for defaults).
- m_valid and s_ready are never high in the same cycle. s_valid outside RECV is ignored (no write, no counter change).
- Counters are $clog2-wide and wrap explicitly to 0 at terminal count, never by overflow.

Test Plan:
- Nominal: TX mem = 0x10..0x17; m_ready=1; result source returns 0xA0..0xA3 with s_last on 4th → m_last only on 0x17, rx writes adr0..3 = 0xA0..0xA3, done pulse at cycle 14 after start, len_err=0.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly → every word 0x10..0x17 sent exactly once, in order; m_data stable while m_ready=0; m_valid never drops in SEND.
- Early last: s_last on 2nd result word (0xA1) → rx writes adr0,1 only, len_err=1, done next cycle, IDLE after.
- Missing last: 4 result words, s_last never asserted → 4 writes, len_err=1; next start clears len_err to 0.
- Reset mid-frame: rst_n low after 3rd TX beat → all outputs 0 immediately (async); new start resends from 0x10 with tx_adr=0.
- Ignored inputs: start pulsed during SEND/RECV and s_valid pulsed during SEND → no restart, no rx_wr, frame completes normally.
